// File: rtl/adc_trigger_seq_pkg.sv
// Shared state encoding and default widths for the ADC trigger sequencer.
package adc_trigger_seq_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_FILL    = 3'd1;
  localparam logic [STATE_W-1:0] ST_ARMED   = 3'd2;
  localparam logic [STATE_W-1:0] ST_POST    = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLDOFF = 3'd4;

  // Encodings 5-7 are never entered deliberately; fall back here if seen.
  localparam logic [STATE_W-1:0] ST_RECOVER = ST_IDLE;

  localparam int DEFAULT_COUNT_WIDTH      = 16;
  localparam int DEFAULT_TRIG_COUNT_WIDTH = 32;
  localparam int DEFAULT_QUALIFY_COUNT    = 3;

endpackage

// File: rtl/adc_trigger_sequencer_qualifier.sv
// Trigger qualifier: with ADC_TRIGGER_QUALIFY_EN a trigger needs QUALIFY_COUNT consecutive
// valid exceeding samples while armed; otherwise any valid exceeding sample qualifies.
module adc_trigger_qualifier #(
  parameter int QUALIFY_COUNT = 3
) (
  input  logic adcClk,
  input  logic adcReset,
  input  logic clear,
  input  logic armed,
  input  logic valid,
  input  logic exceeds,
  output logic trigger
);

`ifdef ADC_TRIGGER_QUALIFY_EN
  localparam int RUN_W = $clog2(QUALIFY_COUNT + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(QUALIFY_COUNT - 1);

  logic [RUN_W-1:0] run;

  // Invalid cycles hold the run; only a valid sample with the flag clear breaks it.
  always_ff @(posedge adcClk) begin
    if (adcReset || clear || !armed) begin
      run <= '0;
    end else if (valid) begin
      if (!exceeds) begin
        run <= '0;
      end else if (run != RUN_LAST) begin
        run <= run + RUN_W'(1);
      end
    end
  end

  assign trigger = armed && valid && exceeds && (run == RUN_LAST);
`else
  logic unused_qual;
  assign unused_qual = ^{adcClk, adcReset, clear, 32'(QUALIFY_COUNT)};

  assign trigger = armed && valid && exceeds;
`endif

endmodule

// File: rtl/adc_trigger_sequencer.sv
// Single-pass ADC capture sequencer: pre-trigger fill, armed wait, post-trigger capture, holdoff.
// Define ADC_TRIGGER_QUALIFY_EN to require QUALIFY_COUNT consecutive exceedances per trigger.
//
// state   | meaning
// IDLE    | waiting for adcArm
// FILL    | writing pre-trigger history
// ARMED   | history keeps writing, waiting for the trigger sample
// POST    | capturing post-trigger samples
// HOLDOFF | ignoring samples before the next re-fill
module adc_trigger_sequencer
  import adc_trigger_seq_pkg::*;
#(
  parameter int COUNT_WIDTH      = DEFAULT_COUNT_WIDTH,
  parameter int TRIG_COUNT_WIDTH = DEFAULT_TRIG_COUNT_WIDTH,
  parameter int QUALIFY_COUNT    = DEFAULT_QUALIFY_COUNT
) (
  input  logic                        adcClk,
  input  logic                        adcReset,
  input  logic                        adcArm,
  input  logic                        adcAbort,
  input  logic                        adcAutoRearm,
  input  logic [COUNT_WIDTH-1:0]      adcPretrigSamples,
  input  logic [COUNT_WIDTH-1:0]      adcPosttrigSamples,
  input  logic [COUNT_WIDTH-1:0]      adcHoldoffSamples,
  input  logic                        adcValid,
  input  logic                        adcExceedsThreshold,
  output logic                        adcCaptureEnable,
  output logic                        adcTriggerMarker,
  output logic                        adcCaptureDone,
  output logic                        adcBusy,
  output logic [STATE_W-1:0]          adcState,
  output logic [TRIG_COUNT_WIDTH-1:0] adcTriggerCount
);

  state_t                 state, state_nxt;
  logic [COUNT_WIDTH-1:0] remain, remain_nxt;
  logic [COUNT_WIDTH-1:0] post_lat, post_nxt;
  logic [COUNT_WIDTH-1:0] hold_lat, hold_nxt;
  logic                   en_nxt, marker_nxt, done_nxt, trig_inc;
  logic                   post_exit, refill, qual_trig;

  adc_trigger_qualifier #(
    .QUALIFY_COUNT(QUALIFY_COUNT)
  ) u_qualifier (
    .adcClk  (adcClk),
    .adcReset(adcReset),
    .clear   (adcAbort),
    .armed   (state == ST_ARMED),
    .valid   (adcValid),
    .exceeds (adcExceedsThreshold),
    .trigger (qual_trig)
  );

  // remain is a down-counter of valid samples left in the current phase.
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    post_nxt   = post_lat;
    hold_nxt   = hold_lat;
    en_nxt     = 1'b0;
    marker_nxt = 1'b0;
    done_nxt   = 1'b0;
    trig_inc   = 1'b0;
    post_exit  = 1'b0;
    refill     = 1'b0;

    case (state)
      ST_IDLE: begin
        refill = adcArm;
      end
      ST_FILL: begin
        en_nxt = adcValid;
        if (adcValid) begin
          if (remain == COUNT_WIDTH'(1)) state_nxt = ST_ARMED;
          remain_nxt = remain - COUNT_WIDTH'(1);
        end
      end
      ST_ARMED: begin
        en_nxt = adcValid;
        if (qual_trig) begin
          marker_nxt = 1'b1;
          trig_inc   = 1'b1;
          if (post_lat != '0) begin
            state_nxt  = ST_POST;
            remain_nxt = post_lat;
          end else begin
            done_nxt  = 1'b1;
            post_exit = 1'b1;
          end
        end
      end
      ST_POST: begin
        en_nxt = adcValid;
        if (adcValid) begin
          if (remain == COUNT_WIDTH'(1)) begin
            done_nxt  = 1'b1;
            post_exit = 1'b1;
          end
          remain_nxt = remain - COUNT_WIDTH'(1);
        end
      end
      ST_HOLDOFF: begin
        if (adcValid) begin
          if (remain == COUNT_WIDTH'(1)) refill = 1'b1;
          remain_nxt = remain - COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = ST_RECOVER;
      end
    endcase

    if (post_exit) begin
      if (!adcAutoRearm) begin
        state_nxt = ST_IDLE;
      end else if (hold_lat != '0) begin
        state_nxt  = ST_HOLDOFF;
        remain_nxt = hold_lat;
      end else begin
        refill = 1'b1;
      end
    end

    // Counts are sampled only here: on arm and at every re-fill.
    if (refill) begin
      post_nxt   = adcPosttrigSamples;
      hold_nxt   = adcHoldoffSamples;
      remain_nxt = adcPretrigSamples;
      state_nxt  = (adcPretrigSamples != '0) ? ST_FILL : ST_ARMED;
    end

    if (adcAbort) begin
      state_nxt  = ST_IDLE;
      en_nxt     = 1'b0;
      marker_nxt = 1'b0;
      done_nxt   = 1'b0;
      trig_inc   = 1'b0;
    end
  end

  always_ff @(posedge adcClk) begin
    if (adcReset) begin
      state            <= ST_IDLE;
      remain           <= '0;
      post_lat         <= '0;
      hold_lat         <= '0;
      adcCaptureEnable <= 1'b0;
      adcTriggerMarker <= 1'b0;
      adcCaptureDone   <= 1'b0;
      adcBusy          <= 1'b0;
      adcTriggerCount  <= '0;
    end else begin
      state            <= state_nxt;
      remain           <= remain_nxt;
      post_lat         <= post_nxt;
      hold_lat         <= hold_nxt;
      adcCaptureEnable <= en_nxt;
      adcTriggerMarker <= marker_nxt;
      adcCaptureDone   <= done_nxt;
      adcBusy          <= (state_nxt != ST_IDLE);
      if (trig_inc) adcTriggerCount <= adcTriggerCount + TRIG_COUNT_WIDTH'(1);
    end
  end

  assign adcState = state;

endmodule

// File: tb/tb_adc_trigger_sequencer.sv
// Self-checking bench for adc_trigger_sequencer: directed scenarios, a vector table and
// randomized traffic, all compared against a phase/sample-count reference model.
module tb_adc_trigger_sequencer;
  import adc_trigger_seq_pkg::*;

`ifdef ADC_TRIGGER_QUALIFY_EN
  localparam int QN = 3;
`else
  localparam int QN = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, arm, abort_r, auto_r, valid, exceed;
  logic [15:0] pre, post, hold;
  logic        en, mk, dn, busy;
  logic [2:0]  st;
  logic [31:0] tcnt;

  adc_trigger_sequencer #(
    .COUNT_WIDTH(16),
    .TRIG_COUNT_WIDTH(32),
    .QUALIFY_COUNT(3)
  ) dut (
    .adcClk             (clk),
    .adcReset           (rst),
    .adcArm             (arm),
    .adcAbort           (abort_r),
    .adcAutoRearm       (auto_r),
    .adcPretrigSamples  (pre),
    .adcPosttrigSamples (post),
    .adcHoldoffSamples  (hold),
    .adcValid           (valid),
    .adcExceedsThreshold(exceed),
    .adcCaptureEnable   (en),
    .adcTriggerMarker   (mk),
    .adcCaptureDone     (dn),
    .adcBusy            (busy),
    .adcState           (st),
    .adcTriggerCount    (tcnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase number plus valid samples seen so far in that phase.
  int          m_ph, m_n, m_pre, m_post, m_hold, m_run;
  logic [31:0] m_cnt;
  bit          m_en, m_mk, m_dn;

  task automatic m_enter_armed();
    m_ph = 2; m_n = 0; m_run = 0;
  endtask

  task automatic m_relatch();
    m_pre = int'(pre); m_post = int'(post); m_hold = int'(hold); m_n = 0;
    if (m_pre > 0) m_ph = 1;
    else m_enter_armed();
  endtask

  task automatic m_finish_post();
    m_dn = 1'b1;
    if (!auto_r) m_ph = 0;
    else if (m_hold > 0) begin m_ph = 4; m_n = 0; end
    else m_relatch();
  endtask

  task automatic model_update();
    m_en = 1'b0; m_mk = 1'b0; m_dn = 1'b0;
    if (rst) begin
      m_ph = 0; m_n = 0; m_run = 0; m_cnt = '0;
      return;
    end
    if (abort_r) begin
      m_ph = 0; m_run = 0;
      return;
    end
    case (m_ph)
      0: if (arm) m_relatch();
      1: if (valid) begin
        m_en = 1'b1; m_n++;
        if (m_n >= m_pre) m_enter_armed();
      end
      2: if (valid) begin
        m_en = 1'b1;
        m_run = exceed ? m_run + 1 : 0;
        if (m_run >= QN) begin
          m_mk = 1'b1; m_cnt = m_cnt + 32'd1;
          if (m_post > 0) begin m_ph = 3; m_n = 0; end
          else m_finish_post();
        end
      end
      3: if (valid) begin
        m_en = 1'b1; m_n++;
        if (m_n >= m_post) m_finish_post();
      end
      4: if (valid) begin
        m_n++;
        if (m_n >= m_hold) m_relatch();
      end
      default: m_ph = 0;
    endcase
  endtask

  // Per-scenario record of which valid-sample indices got enable/marker/done.
  int sidx;
  bit en_map [0:255];
  int mk_q[$];
  int dn_q[$];

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("enable", en, m_en);
    chk("marker", mk, m_mk);
    chk("done", dn, m_dn);
    chk("state", st, m_ph);
    chk("busy", busy, m_ph != 0);
    chk("trig_count", tcnt, m_cnt);
    if (en === 1'b1) en_map[sidx] = 1'b1;
    if (mk === 1'b1) mk_q.push_back(sidx);
    if (dn === 1'b1) dn_q.push_back(sidx);
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int count_en(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(en_map[i]);
    return c;
  endfunction

  function automatic logic [63:0] tmask(input int idx);
    logic [63:0] m = '0;
    for (int k = 0; k < QN; k++) m[idx-k] = 1'b1;
    return m;
  endfunction

  // Reset, arm once, then feed nval valid samples (one every vper cycles).
  task automatic scenario(input int p_pre, input int p_post, input int p_hold, input bit p_auto,
                          input int vper, input int nval, input logic [63:0] exmask,
                          input int abort_at);
    rst = 1'b1; arm = 1'b0; abort_r = 1'b0; valid = 1'b0; exceed = 1'b0;
    auto_r = p_auto; pre = 16'(p_pre); post = 16'(p_post); hold = 16'(p_hold);
    sidx = 0;
    step();
    chk("reset_enable", en, 0);
    chk("reset_state", st, ST_IDLE);
    chk("reset_count", tcnt, 0);
    rst = 1'b0;
    foreach (en_map[i]) en_map[i] = 1'b0;
    mk_q.delete(); dn_q.delete();
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 1; i <= nval; i++) begin
      for (int k = 1; k < vper; k++) begin
        sidx = 0; valid = 1'b0; exceed = 1'($urandom_range(0, 1));
        step();
      end
      sidx = i; valid = 1'b1; exceed = exmask[i];
      if (i == abort_at) begin abort_r = 1'b1; arm = 1'b1; end
      step();
      abort_r = 1'b0; arm = 1'b0;
    end
    sidx = 0; valid = 1'b0; exceed = 1'b0;
    step(); step();
  endtask

  typedef struct {
    logic       arm, abt, vld, exc;
    logic       en, mk, dn;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1; arm = 1'b0; abort_r = 1'b0; auto_r = 1'b0; valid = 1'b0; exceed = 1'b0;
    pre = '0; post = '0; hold = '0;
    m_ph = 0; m_n = 0; m_pre = 0; m_post = 0; m_hold = 0; m_run = 0; m_cnt = '0;
    sidx = 0;

    // Pre-trigger fill: 4 fill + 6 armed + 6 post enables.
    scenario(4, 6, 0, 1'b0, 1, 18, tmask(10), -1);
    chk("pf_enables", count_en(1, 255), 16);
    chk("pf_marker_n", mk_q.size(), 1);
    chk("pf_marker_at", qat(mk_q, 0), 10);
    chk("pf_done_n", dn_q.size(), 1);
    chk("pf_done_at", qat(dn_q, 0), 16);
    chk("pf_state", st, ST_IDLE);
    chk("pf_count", tcnt, 1);

    // Gated valid; exceedances during FILL are ignored.
    scenario(2, 3, 0, 1'b0, 3, 12, tmask(6) | 64'h6, -1);
    chk("gv_marker_at", qat(mk_q, 0), 6);
    chk("gv_done_at", qat(dn_q, 0), 9);
    chk("gv_enables", count_en(1, 255), 9);
    chk("gv_count", tcnt, 1);

    // Auto re-arm with holdoff 5; exceedances in holdoff and re-fill are ignored.
    scenario(2, 3, 5, 1'b1, 1, 23, tmask(5) | tmask(18) | (64'd1 << 11) | (64'd1 << 14), -1);
    chk("ar_marker_n", mk_q.size(), 2);
    chk("ar_marker1_at", qat(mk_q, 0), 5);
    chk("ar_marker2_at", qat(mk_q, 1), 18);
    chk("ar_done1_at", qat(dn_q, 0), 8);
    chk("ar_done2_at", qat(dn_q, 1), 21);
    chk("ar_holdoff_enables", count_en(9, 13), 0);
    chk("ar_refill_enable", en_map[14], 1);
    chk("ar_count", tcnt, 2);
    chk("ar_state", st, ST_HOLDOFF);

    // Abort with simultaneous arm at post-sample 2 of 6.
    scenario(1, 6, 0, 1'b0, 1, 10, tmask(4), 6);
    chk("ab_marker_at", qat(mk_q, 0), 4);
    chk("ab_done_n", dn_q.size(), 0);
    chk("ab_enable_pre", en_map[5], 1);
    chk("ab_enable_abort", en_map[6], 0);
    chk("ab_enables", count_en(1, 255), 5);
    chk("ab_state", st, ST_IDLE);
    chk("ab_count", tcnt, 1);
    pre = 16'd2; arm = 1'b1;
    step();
    chk("ab_rearm_state", st, ST_FILL);
    arm = 1'b0; valid = 1'b1; exceed = 1'b0;
    step(); step();
    chk("ab_rearm_armed", st, ST_ARMED);
    valid = 1'b0;

    // Qualification pattern 1,1,0,1,1,1 with zero-length phases.
    scenario(0, 0, 0, 1'b0, 1, 8, 64'h76, -1);
    chk("q_marker_n", mk_q.size(), 1);
    chk("q_marker_at", qat(mk_q, 0), (QN == 3) ? 6 : 1);
    chk("q_done_at", qat(dn_q, 0), (QN == 3) ? 6 : 1);
    chk("q_count", tcnt, 1);

    // Zero-length phases as a vector table.
    rst = 1'b1; pre = '0; post = '0; hold = '0; auto_r = 1'b0;
    step();
    rst = 1'b0;
    tbl.push_back('{arm: 1, abt: 0, vld: 1, exc: 1, en: 0, mk: 0, dn: 0, st: ST_ARMED});
    tbl.push_back('{arm: 0, abt: 0, vld: 1, exc: 0, en: 1, mk: 0, dn: 0, st: ST_ARMED});
    tbl.push_back('{arm: 0, abt: 0, vld: 0, exc: 1, en: 0, mk: 0, dn: 0, st: ST_ARMED});
    for (int i = 1; i < QN; i++)
      tbl.push_back('{arm: 0, abt: 0, vld: 1, exc: 1, en: 1, mk: 0, dn: 0, st: ST_ARMED});
    tbl.push_back('{arm: 0, abt: 0, vld: 1, exc: 1, en: 1, mk: 1, dn: 1, st: ST_IDLE});
    tbl.push_back('{arm: 0, abt: 0, vld: 1, exc: 1, en: 0, mk: 0, dn: 0, st: ST_IDLE});
    tbl.push_back('{arm: 1, abt: 1, vld: 0, exc: 0, en: 0, mk: 0, dn: 0, st: ST_IDLE});
    tbl.push_back('{arm: 1, abt: 0, vld: 0, exc: 0, en: 0, mk: 0, dn: 0, st: ST_ARMED});
    tbl.push_back('{arm: 0, abt: 1, vld: 1, exc: 1, en: 0, mk: 0, dn: 0, st: ST_IDLE});
    foreach (tbl[i]) begin
      arm = tbl[i].arm; abort_r = tbl[i].abt; valid = tbl[i].vld; exceed = tbl[i].exc;
      step();
      chk($sformatf("tbl%0d_enable", i), en, tbl[i].en);
      chk($sformatf("tbl%0d_marker", i), mk, tbl[i].mk);
      chk($sformatf("tbl%0d_done", i), dn, tbl[i].dn);
      chk($sformatf("tbl%0d_state", i), st, tbl[i].st);
    end
    chk("tbl_count", tcnt, 1);

    // Randomized traffic against the model, counts changing mid-phase.
    arm = 1'b0; abort_r = 1'b0; valid = 1'b0; exceed = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sidx = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) pre  = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) post = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) hold = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) auto_r = ~auto_r;
      arm     = 1'($urandom_range(0, 7) == 0);
      abort_r = 1'($urandom_range(0, 49) == 0);
      valid   = 1'($urandom_range(0, 9) < 6);
      exceed  = 1'($urandom_range(0, 9) < 4);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
